// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: serialises 256-bit line read/write requests from the
// cache arbiter into 64-bit memory bursts and returns a one-cycle line response.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [31:0]        line_address_i,
  input  logic [LINE_W-1:0]  line_wdata_i,
  output logic [LINE_W-1:0]  line_rdata_o,
  output logic               line_resp_o,

  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [31:0]        mem_address_o,
  output logic [BURST_W-1:0] mem_wdata_o,
  input  logic [BURST_W-1:0] mem_rdata_i,
  input  logic               mem_resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte offset within a line so bursts always start line-aligned.
  localparam logic [31:0] ADDR_MASK = ~32'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat;
  logic [LINE_W-1:0]  wbuf;

  // Beat selection from the captured line; line-side wdata is not used after capture.
  assign mem_wdata_o = wbuf[int'(beat)*BURST_W +: BURST_W];

  // NOTE: every register here is updated with <= so all reads in this block
  // see the pre-edge values; the wide line buffers are reset because their
  // reset contents are architecturally visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= '0;
      wbuf          <= '0;
      line_rdata_o  <= '0;
      line_resp_o   <= 1'b0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_address_o <= '0;
    end else begin
      line_resp_o <= 1'b0;
      case (state)
        IDLE: begin
          beat <= '0;
          // Read wins when both requests are (illegally) asserted together.
          if (line_read_i) begin
            mem_address_o <= line_address_i & ADDR_MASK;
            mem_read_o    <= 1'b1;
            state         <= READ;
          end else if (line_write_i) begin
            mem_address_o <= line_address_i & ADDR_MASK;
            wbuf          <= line_wdata_i;
            mem_write_o   <= 1'b1;
            state         <= WRITE;
          end
        end

        READ: begin
          if (mem_resp_i) begin
            line_rdata_o[int'(beat)*BURST_W +: BURST_W] <= mem_rdata_i;
            if (beat == LAST_BEAT) begin
              mem_read_o  <= 1'b0;
              line_resp_o <= 1'b1;
              state       <= RESP;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end

        WRITE: begin
          if (mem_resp_i) begin
            if (beat == LAST_BEAT) begin
              mem_write_o <= 1'b0;
              line_resp_o <= 1'b1;
              state       <= RESP;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end

        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: table of line transactions served
// by a memory model with per-vector response patterns, plus corner sequences.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic         line_read_i;
  logic         line_write_i;
  logic [31:0]  line_address_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [31:0]  mem_address_o;
  logic [63:0]  mem_wdata_o;
  logic [63:0]  mem_rdata_i;
  logic         mem_resp_i;

  cacheline_adaptor dut (
    .clk            (clk),
    .rst            (rst),
    .line_read_i    (line_read_i),
    .line_write_i   (line_write_i),
    .line_address_i (line_address_i),
    .line_wdata_i   (line_wdata_i),
    .line_rdata_o   (line_rdata_o),
    .line_resp_o    (line_resp_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .mem_address_o  (mem_address_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_resp_i     (mem_resp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] wdata;
    logic [255:0] rline;
    logic [15:0]  pat;     // mem_resp_i per burst cycle, LSB first; all ones beyond
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [255:0] sb[$];       // expected read lines, pushed at request time
  logic [255:0] last_line;   // line the read buffer must currently hold
  vec_t vecs[6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic resp_at(input logic [15:0] pat, input int c);
    return (c < 16) ? pat[c[3:0]] : 1'b1;
  endfunction

  function automatic int n_cycles(input logic [15:0] pat);
    int ones = 0;
    for (int c = 0; c < 40; c++) begin
      if (resp_at(pat, c)) ones++;
      if (ones == 4) return c + 1;
    end
    return -1;
  endfunction

  task automatic run_txn(input vec_t v);
    int cyc;
    int beat;
    logic r;
    line_read_i    = v.rd;
    line_write_i   = v.wr;
    line_address_i = v.addr;
    line_wdata_i   = v.wdata;
    mem_resp_i     = 1'b1;                   // stray strobe in IDLE must be ignored
    mem_rdata_i    = 64'hBAD0_BAD0_BAD0_BAD0;
    if (v.rd) sb.push_back(v.rline);
    step();
    // Scramble line-side inputs: the adaptor must use the captured copies.
    line_address_i = ~v.addr;
    line_wdata_i   = ~v.wdata;
    cyc  = 0;
    beat = 0;
    while (!line_resp_o && cyc < 40) begin
      check("mem_read", {255'd0, mem_read_o}, {255'd0, v.rd});
      check("mem_write", {255'd0, mem_write_o}, {255'd0, !v.rd && v.wr});
      check("mem_addr", {224'd0, mem_address_o}, {224'd0, v.exp_addr});
      if (!v.rd && beat < 4) begin
        check("mem_wdata", {192'd0, mem_wdata_o}, {192'd0, v.wdata[beat*64 +: 64]});
        check("rdata_hold_wr", line_rdata_o, last_line);
      end
      r = resp_at(v.pat, cyc);
      mem_resp_i  = r;
      mem_rdata_i = (r && beat < 4) ? v.rline[beat*64 +: 64] : 64'(cyc) ^ 64'hDEAD_0000_0000_0000;
      step();
      if (r) beat++;
      cyc++;
    end
    check("resp_seen", {255'd0, line_resp_o}, {255'd0, 1'b1});
    check("burst_cycles", 256'(cyc), 256'(n_cycles(v.pat)));
    check("mem_idle_in_resp", {254'd0, mem_read_o, mem_write_o}, 256'd0);
    if (v.rd) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: unexpected read response, queue empty");
      end else begin
        last_line = sb.pop_front();
        check("rdata", line_rdata_o, last_line);
      end
    end else begin
      check("rdata_after_wr", line_rdata_o, last_line);
    end
    // Requester drops its request; a stray strobe in RESP must not touch state.
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    mem_resp_i   = 1'b1;
    mem_rdata_i  = 64'hFEED_FEED_FEED_FEED;
    step();
    mem_resp_i = 1'b0;
    check("resp_one_cycle", {255'd0, line_resp_o}, 256'd0);
    check("rdata_after_resp", line_rdata_o, last_line);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] exp_addr, input logic [255:0] wdata,
                              input logic [255:0] rline, input logic [15:0] pat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.exp_addr = exp_addr;
    v.wdata = wdata; v.rline = rline; v.pat = pat;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, 256'd0,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 16'hFFFF);
    vecs[1] = mk(1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEE0,
                 {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                  64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A}, 256'd0, 16'h0059);
    vecs[2] = mk(1'b1, 1'b0, 32'h8000_001F, 32'h8000_0000, 256'd0,
                 {64'h0123_4567_89AB_CDEF, 64'hF0E1_D2C3_B4A5_9687,
                  64'h5A5A_A5A5_5A5A_A5A5, 64'h8000_0000_0000_0001}, 16'h5555);
    vecs[3] = mk(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0040, {4{64'hEEEE_EEEE_EEEE_EEEE}},
                 {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                  64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001}, 16'hFFFF);
    vecs[4] = mk(1'b0, 1'b1, 32'h1234_5678, 32'h1234_5660,
                 {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                  64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000}, 256'd0, 16'h0033);
    vecs[5] = mk(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 256'd0,
                 {4{64'hCAFE_F00D_CAFE_F00D}}, 16'hFFFF);

    rst = 1'b1;
    line_read_i = 1'b0;
    line_write_i = 1'b0;
    line_address_i = 32'h0;
    line_wdata_i = '0;
    mem_rdata_i = 64'h0;
    mem_resp_i = 1'b0;
    last_line = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_mem_read", {255'd0, mem_read_o}, 256'd0);
    check("rst_mem_write", {255'd0, mem_write_o}, 256'd0);
    check("rst_mem_addr", {224'd0, mem_address_o}, 256'd0);
    check("rst_line_resp", {255'd0, line_resp_o}, 256'd0);
    check("rst_rdata", line_rdata_o, 256'd0);
    check("rst_wdata_beat", {192'd0, mem_wdata_o}, 256'd0);

    // Table: back-to-back transactions, each starting in the IDLE cycle after RESP.
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Stray strobes while idle: nothing moves, read buffer untouched.
    mem_resp_i  = 1'b1;
    mem_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_stray_read", {255'd0, mem_read_o}, 256'd0);
      check("idle_stray_resp", {255'd0, line_resp_o}, 256'd0);
      check("idle_stray_rdata", line_rdata_o, last_line);
    end
    mem_resp_i = 1'b0;

    // Reset after two read beats: burst aborted, no response, buffer cleared.
    line_read_i    = 1'b1;
    line_address_i = 32'h0000_2008;
    sb.push_back({4{64'h7777_7777_7777_7777}});
    step();
    check("abort_mem_read", {255'd0, mem_read_o}, {255'd0, 1'b1});
    mem_resp_i  = 1'b1;
    mem_rdata_i = 64'hA1A1_A1A1_A1A1_A1A1;
    step();
    mem_rdata_i = 64'hB2B2_B2B2_B2B2_B2B2;
    step();
    mem_resp_i  = 1'b0;
    line_read_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    last_line = '0;
    check("abort_mem_read_low", {255'd0, mem_read_o}, 256'd0);
    check("abort_rdata", line_rdata_o, 256'd0);
    check("abort_addr", {224'd0, mem_address_o}, 256'd0);
    check("abort_no_resp", {255'd0, line_resp_o}, 256'd0);
    step();
    check("abort_no_resp_late", {255'd0, line_resp_o}, 256'd0);

    // A fresh read after the abort completes normally.
    run_txn(mk(1'b1, 1'b0, 32'h0000_2008, 32'h0000_2000, 256'd0,
               {64'h4040_4040_4040_4040, 64'h3030_3030_3030_3030,
                64'h2020_2020_2020_2020, 64'h1010_1010_1010_1010}, 16'h00F3));

    check("scoreboard_empty", 256'(sb.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
